// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory bus arbiter.
package mem_arb_pkg;

  // Transaction sequencing: grant in idle, wait for ack in busy, pulse done.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } arb_state_e;

  // Requester identifiers, also the encoding of the owner output.
  localparam logic REQ_CPU  = 1'b0;
  localparam logic REQ_FPGA = 1'b1;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-input round-robin picker: on a tie the requester that did not own
// the bus last time wins; a lone requester always wins.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic cpu_req_i,
  input  logic fpga_req_i,
  input  logic last_owner_i,
  output logic gnt_valid_o,
  output logic gnt_id_o
);

  // Pick a winner from the current request pair.
  always_comb begin
    gnt_valid_o = cpu_req_i | fpga_req_i;
    gnt_id_o    = REQ_CPU;
    if (cpu_req_i && fpga_req_i) begin
      gnt_id_o = (last_owner_i == REQ_CPU) ? REQ_FPGA : REQ_CPU;
    end else if (fpga_req_i) begin
      gnt_id_o = REQ_FPGA;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Data-memory port arbiter between the CPU core and the FPGA I/O front-end.
// One transaction at a time: grant in IDLE, hold the latched command on the
// memory port through BUSY until mem_ack, then a one-cycle done pulse.
// Optional busy timeout is built only when MEMARB_TIMEOUT_EN is defined.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  input  logic              fpga_req,
  input  logic              fpga_wen,
  input  logic [ADDR_W-1:0] fpga_addr,
  input  logic [DATA_W-1:0] fpga_wdata,
  output logic [DATA_W-1:0] fpga_rdata,
  output logic              fpga_done,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              owner,
  output logic              err
);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT must be at least 2");
  end

  arb_state_e state_q, state_d;
  logic              owner_q, owner_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] fpga_rdata_q, fpga_rdata_d;
  logic              cpu_done_q, cpu_done_d;
  logic              fpga_done_q, fpga_done_d;

  logic              gnt_valid;
  logic              gnt_id;
  logic              finish;
  logic              timeout_hit;
  logic [DATA_W-1:0] rdata_cap;

`ifdef MEMARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  mem_arb_rr u_rr (
    .cpu_req_i   (cpu_req),
    .fpga_req_i  (fpga_req),
    .last_owner_i(owner_q),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  // Next-state and registered-output computation for the arbiter FSM.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    mem_en_d     = mem_en_q;
    mem_wen_d    = mem_wen_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    fpga_rdata_d = fpga_rdata_q;
    cpu_done_d   = 1'b0;
    fpga_done_d  = 1'b0;
    finish       = 1'b0;
    timeout_hit  = 1'b0;
    rdata_cap    = mem_rdata;
`ifdef MEMARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          // Requester fields are sampled only here; later changes are ignored.
          owner_d  = gnt_id;
          mem_en_d = 1'b1;
          state_d  = StBusy;
          if (gnt_id == REQ_FPGA) begin
            mem_wen_d   = fpga_wen;
            mem_addr_d  = fpga_addr;
            mem_wdata_d = fpga_wdata;
          end else begin
            mem_wen_d   = cpu_wen;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
          end
`ifdef MEMARB_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end

      StBusy: begin
        finish = mem_ack;
`ifdef MEMARB_TIMEOUT_EN
        // An ack on the final counted edge wins over the timeout.
        if (!mem_ack) begin
          if (cnt_q == CntLast) begin
            timeout_hit = 1'b1;
            finish      = 1'b1;
            rdata_cap   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        err_d = timeout_hit;
`endif
        if (finish) begin
          state_d   = StDone;
          mem_en_d  = 1'b0;
          mem_wen_d = 1'b0;
          if (owner_q == REQ_FPGA) begin
            fpga_done_d  = 1'b1;
            fpga_rdata_d = rdata_cap;
          end else begin
            cpu_done_d  = 1'b1;
            cpu_rdata_d = rdata_cap;
          end
        end
      end

      StDone: begin
        // No arbitration here: the requester drops req during done.
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= StIdle;
      owner_q      <= REQ_CPU;
      mem_en_q     <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      fpga_rdata_q <= '0;
      cpu_done_q   <= 1'b0;
      fpga_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      mem_en_q     <= mem_en_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      fpga_rdata_q <= fpga_rdata_d;
      cpu_done_q   <= cpu_done_d;
      fpga_done_q  <= fpga_done_d;
    end
  end

`ifdef MEMARB_TIMEOUT_EN
  // Busy-cycle counter and timeout error pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign owner      = owner_q;
  assign mem_en     = mem_en_q;
  assign mem_wen    = mem_wen_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign fpga_rdata = fpga_rdata_q;
  assign cpu_done   = cpu_done_q;
  assign fpga_done  = fpga_done_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a table of single-requester
// transactions plus hand-written tie, fairness, stability, reset and
// no-ack sequences. Build with MEMARB_TIMEOUT_EN to check the timeout path.
module tb_mem_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          nrst;
  logic          cpu_req, cpu_wen, fpga_req, fpga_wen;
  logic [AW-1:0] cpu_addr, fpga_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, fpga_wdata, cpu_rdata, fpga_rdata;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          cpu_done, fpga_done, mem_en, mem_wen, mem_ack, owner, err;

  mem_bus_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(16)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .cpu_req   (cpu_req),
    .cpu_wen   (cpu_wen),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_done  (cpu_done),
    .fpga_req  (fpga_req),
    .fpga_wen  (fpga_wen),
    .fpga_addr (fpga_addr),
    .fpga_wdata(fpga_wdata),
    .fpga_rdata(fpga_rdata),
    .fpga_done (fpga_done),
    .mem_en    (mem_en),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .owner     (owner),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fpga;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] mrdata;
    logic [31:0] exp_rdata;
    logic        exp_owner;
  } vec_t;

  vec_t        vecs[5];
  int          nvec  = 0;
  int          nfail = 0;
  logic [31:0] model_cpu_rdata;
  logic [31:0] model_fpga_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    nrst = 1'b0;
    #1;
    repeat (2) step();
    cpu_req  = 1'b0;
    fpga_req = 1'b0;
    mem_ack  = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    model_cpu_rdata  = '0;
    model_fpga_rdata = '0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " mem_en"}, {31'd0, mem_en}, 32'd0);
    chk({tag, " mem_wen"}, {31'd0, mem_wen}, 32'd0);
    chk({tag, " mem_addr"}, mem_addr, 32'd0);
    chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, " cpu_done"}, {31'd0, cpu_done}, 32'd0);
    chk({tag, " fpga_done"}, {31'd0, fpga_done}, 32'd0);
    chk({tag, " cpu_rdata"}, cpu_rdata, 32'd0);
    chk({tag, " fpga_rdata"}, fpga_rdata, 32'd0);
    chk({tag, " owner"}, {31'd0, owner}, 32'd0);
    chk({tag, " err"}, {31'd0, err}, 32'd0);
  endtask

  // One single-requester transaction from the table; starts and ends idle.
  task automatic run_vec(input vec_t v, input int idx);
    int en_cnt;
    int wen_cnt;
    string t;
    t = $sformatf("vec%0d", idx);
    en_cnt  = 0;
    wen_cnt = 0;
    if (v.fpga) begin
      fpga_req = 1'b1; fpga_wen = v.wen; fpga_addr = v.addr; fpga_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_wen = v.wen; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    mem_rdata = 32'hDEAD_BEEF;
    step();
    chk({t, " mem_addr"}, mem_addr, v.addr);
    chk({t, " mem_wdata"}, mem_wdata, v.wdata);
    chk({t, " owner"}, {31'd0, owner}, {31'd0, v.exp_owner});
    repeat (v.delay) begin
      en_cnt  += int'(mem_en);
      wen_cnt += int'(mem_wen);
      step();
    end
    en_cnt  += int'(mem_en);
    wen_cnt += int'(mem_wen);
    mem_ack   = 1'b1;
    mem_rdata = v.mrdata;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    cpu_req   = 1'b0;
    fpga_req  = 1'b0;
    chk({t, " mem_en cycles"}, en_cnt, v.delay + 1);
    chk({t, " mem_wen cycles"}, wen_cnt, v.wen ? v.delay + 1 : 0);
    chk({t, " mem_en after ack"}, {31'd0, mem_en}, 32'd0);
    chk({t, " err"}, {31'd0, err}, 32'd0);
    if (v.fpga) begin
      model_fpga_rdata = v.exp_rdata;
      chk({t, " fpga_done"}, {31'd0, fpga_done}, 32'd1);
      chk({t, " cpu_done"}, {31'd0, cpu_done}, 32'd0);
    end else begin
      model_cpu_rdata = v.exp_rdata;
      chk({t, " cpu_done"}, {31'd0, cpu_done}, 32'd1);
      chk({t, " fpga_done"}, {31'd0, fpga_done}, 32'd0);
    end
    chk({t, " cpu_rdata"}, cpu_rdata, model_cpu_rdata);
    chk({t, " fpga_rdata"}, fpga_rdata, model_fpga_rdata);
    step();
    chk({t, " done low"}, {30'd0, cpu_done, fpga_done}, 32'd0);
  endtask

  initial begin
    int done_at;

    vecs[0] = '{1'b0, 1'b0, 32'd220, 32'h0, 0, 32'h2A, 32'h2A, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'd240, 32'h55, 5, 32'h0BAD_0001, 32'h0BAD_0001, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 32'h100, 32'h1234, 2, 32'h0000_BEEF, 32'h0000_BEEF, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'd260, 32'h0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};

    cpu_req = 0; cpu_wen = 0; cpu_addr = '0; cpu_wdata = '0;
    fpga_req = 0; fpga_wen = 0; fpga_addr = '0; fpga_wdata = '0;
    mem_rdata = '0; mem_ack = 0;
    apply_reset();
    step();
    chk_reset_values("reset");

    // Tie straight after reset: FPGA first, CPU next with no lost request.
    cpu_req = 1; cpu_addr = 32'h300; fpga_req = 1; fpga_addr = 32'h400;
    step();
    chk("tie first addr", mem_addr, 32'h400);
    chk("tie first owner", {31'd0, owner}, 32'd1);
    mem_ack = 1; mem_rdata = 32'h11;
    step();
    mem_ack = 0; fpga_req = 0;
    chk("tie fpga_done", {31'd0, fpga_done}, 32'd1);
    chk("tie cpu_done quiet", {31'd0, cpu_done}, 32'd0);
    step();
    chk("tie no grant in done", {31'd0, mem_en}, 32'd0);
    step();
    chk("tie second addr", mem_addr, 32'h300);
    chk("tie second owner", {31'd0, owner}, 32'd0);
    mem_ack = 1; mem_rdata = 32'h22;
    step();
    mem_ack = 0; cpu_req = 0;
    chk("tie cpu_done", {31'd0, cpu_done}, 32'd1);
    chk("tie cpu_rdata", cpu_rdata, 32'h22);
    step();
    model_cpu_rdata = 32'h22; model_fpga_rdata = 32'h11;

    // Both requests held: grants alternate F,C,F,C,F,C.
    cpu_req = 1; fpga_req = 1; cpu_addr = 32'hC0; fpga_addr = 32'hF0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("fair%0d owner", i), {31'd0, owner}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("fair%0d addr", i), mem_addr, (i % 2 == 0) ? 32'hF0 : 32'hC0);
      mem_ack = 1; mem_rdata = 32'(i);
      step();
      mem_ack = 0;
      chk($sformatf("fair%0d done", i), {30'd0, fpga_done, cpu_done},
          (i % 2 == 0) ? 32'd2 : 32'd1);
      step();
    end
    cpu_req = 0; fpga_req = 0;
    model_fpga_rdata = 32'd4; model_cpu_rdata = 32'd5;
    step();

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], i);
    end

    // Requester fields changing mid-transaction must not reach the port.
    fpga_req = 1; fpga_wen = 0; fpga_addr = 32'd260;
    step();
    fpga_addr = 32'd280; fpga_wen = 1; fpga_req = 0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stable addr %0d", i), mem_addr, 32'd260);
      chk($sformatf("stable wen %0d", i), {31'd0, mem_wen}, 32'd0);
      step();
    end
    mem_ack = 1; mem_rdata = 32'h77;
    step();
    mem_ack = 0;
    chk("stable done after dropped req", {31'd0, fpga_done}, 32'd1);
    chk("stable rdata", fpga_rdata, 32'h77);
    step();

    // Ack while idle is ignored.
    mem_ack = 1; mem_rdata = 32'h99;
    step();
    mem_ack = 0;
    chk("stray ack mem_en", {31'd0, mem_en}, 32'd0);
    step();
    chk("stray ack done", {30'd0, cpu_done, fpga_done}, 32'd0);
    chk("stray ack fpga_rdata", fpga_rdata, 32'h77);

    // Reset during BUSY drops the transaction.
    cpu_req = 1; cpu_addr = 32'h500;
    step();
    chk("rst pre busy", {31'd0, mem_en}, 32'd1);
    step();
    nrst = 0;
    #1;
    chk_reset_values("midrst");
    cpu_req = 0;
    step();
    @(negedge clk);
    nrst = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("midrst quiet %0d", i), {29'd0, cpu_done, fpga_done, mem_en}, 32'd0);
    end

    // No ack at all: timeout when built in, otherwise wait forever.
    cpu_req = 1; cpu_addr = 32'h600; cpu_wen = 0;
    step();
    cpu_req = 0;
    done_at = 0;
    for (int i = 1; i <= 100 && done_at == 0; i++) begin
      step();
      if (cpu_done) begin
        done_at = i;
`ifdef MEMARB_TIMEOUT_EN
        chk("timeout err", {31'd0, err}, 32'd1);
        chk("timeout rdata", cpu_rdata, 32'd0);
`endif
      end
    end
`ifdef MEMARB_TIMEOUT_EN
    chk("timeout cycle", done_at, 32'd16);
    step();
    chk("timeout err pulse", {31'd0, err}, 32'd0);
`else
    chk("no-ack never done", done_at, 32'd0);
    chk("no-ack still busy", {31'd0, mem_en}, 32'd1);
    chk("no-ack err", {31'd0, err}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single data-memory port between the CPU core and the FPGA I/O front-end (keypad/LCD calculator logic), one transaction at a time. It arbitrates round-robin when both requesters are pending, holds the winner's command stable on the memory port until acknowledge, and returns read data with a one-cycle done pulse. It sits between both masters and the data memory, replacing direct enable-based muxing.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, max BUSY cycles without ack (used only with MEMARB_TIMEOUT_EN); must be ≥2

Ports:
- clk  in  1  single clock, all state on rising edge
- nrst  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU transaction request; hold until cpu_done
- cpu_wen  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  read data, valid while cpu_done=1
- cpu_done  out  1  one-cycle completion pulse
- fpga_req, fpga_wen, fpga_addr, fpga_wdata, fpga_rdata, fpga_done: same as cpu_* for the FPGA front-end
- mem_en  out  1  memory access strobe
- mem_wen  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion
- owner  out  1  0 = CPU, 1 = FPGA; current/last grant
- err  out  1  one-cycle timeout pulse, coincident with done

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if exactly one req is high, grant it. If both are high, grant the one that is not `owner`. Latch wen/addr/wdata into registers, set `owner`, then go to BUSY. If neither req is high, stay in IDLE.
- BUSY:
  - mem_en=1; mem_wen/addr/wdata come from the latched registers.
  - On mem_ack: capture mem_rdata (writes capture it too), go to DONE.
- DONE:
  - Assert the owner's done for one cycle; that requester's rdata = captured value. The other requester's done=0 and its rdata holds its last value.
  - Go to IDLE unconditionally; no arbitration happens in DONE.
- Requester fields are sampled only in the IDLE grant cycle. Changes afterwards are ignored.
- A req dropped while BUSY does not abort the access. done still pulses.
- A req of the losing requester stays pending and is granted on the next IDLE cycle.
- Requesters must deassert req in the cycle done is high. A req still high at the IDLE edge is treated as a new transaction.

## Timing
- Reset values:
  - state=IDLE, owner=0 (so the FPGA wins the first tie).
  - mem_en=0, mem_wen=0, mem_addr=0, mem_wdata=0.
  - cpu_done=0, fpga_done=0, cpu_rdata=0, fpga_rdata=0, err=0.
- All outputs are registered.
- Cycle timeline:
  - Edge E0 samples req in IDLE; mem_en is high from E0.
  - Edge Ek samples mem_ack=1; done is high from Ek to Ek+1.
  - State is IDLE at Ek+1; next grant is at Ek+2 at the earliest.
- Minimum req-to-done: 2 edges (ack in the first BUSY cycle).
- mem_ack outside BUSY is ignored.
- Reset mid-BUSY drops the transaction: no done, mem_en low immediately.

## Configuration
- MEMARB_TIMEOUT_EN defined:
  - A BUSY cycle counter starts at 0 on entry.
  - If the count reaches TIMEOUT-1 with mem_ack low, go to DONE with captured rdata=0 and err=1 during the done cycle.
  - An ack on that same edge takes precedence (normal completion).
- Not defined: BUSY waits indefinitely, err is tied to 0, and no counter is built.

## Structure
- Package mem_arb_pkg holds:
  - the enum for IDLE/BUSY/DONE;
  - the requester-id constants REQ_CPU=1'b0, REQ_FPGA=1'b1.
- One sub-module, mem_arb_rr: combinational two-input round-robin picker. Inputs: req pair, last owner. Outputs: grant valid and grant id.

## Test plan
- CPU read alone: cpu_req, addr=220, mem_ack one cycle later with rdata=0x2A -> cpu_done one cycle, cpu_rdata=0x2A, owner=0, fpga_done stays 0.
- Simultaneous requests after reset: both req -> FPGA granted first (mem_addr=FPGA addr). CPU is granted at the next IDLE with no dropped request.
- Fairness: both req held continuously for 6 transactions -> grants strictly alternate F,C,F,C,F,C.
- Stable command: change fpga_addr 260->280 during BUSY -> mem_addr stays 260 until ack.
- Ack delayed 5 cycles, write 0x55 to 240 -> mem_en/mem_wen high exactly 6 cycles, then one done pulse.
- With MEMARB_TIMEOUT_EN and TIMEOUT=16, no ack -> done+err pulse after 16 BUSY cycles, rdata=0. Without the macro, it stays BUSY at cycle 100. Reset asserted mid-BUSY -> all outputs go to reset values, no done.
